control_sequencer: RTL and testbench

Hardwired control unit that drives the datapath's strobe inputs: the R*in/R*out, PC/MAR/MDR/IR/Y/Z/HI/LO enables, read and the ALU opcode.
Each instruction is sequenced as fetch T0–T2, then execute T3–T6 decoded from IR.
Supports three-register ALU ops, two-operand NEG/NOT, MUL/DIV with HI/LO writeback, NOP and HALT.
Memory reads use a ready handshake with a timeout.

---
 rtl/cpu_ctrl_pkg.sv | 49 ++++
 rtl/reg_select_decoder.sv | 19 +
 rtl/control_sequencer.sv | 172 +++++++++++++++++
 tb/tb_control_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, IR layout,
// sequencer state encoding and opcode classification.
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // IR field positions (LSB of each field)
  localparam int unsigned IR_OPC_LSB = 27;
  localparam int unsigned IR_RA_LSB  = 23;
  localparam int unsigned IR_RB_LSB  = 19;
  localparam int unsigned IR_RC_LSB  = 15;

  typedef enum logic [3:0] {
    ST_IDLE, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_HALT
  } state_t;

  typedef enum logic [2:0] {
    CL_ALU3, CL_MULDIV, CL_UNARY, CL_NOP, CL_HALT, CL_ILLEGAL
  } op_class_t;

  function automatic op_class_t classify(input logic [4:0] op);
    op_class_t cls;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
      OP_SHRA, OP_SHL, OP_ROR, OP_ROL:   cls = CL_ALU3;
      OP_MUL, OP_DIV:                    cls = CL_MULDIV;
      OP_NEG, OP_NOT:                    cls = CL_UNARY;
      OP_NOP:                            cls = CL_NOP;
      OP_HALT:                           cls = CL_HALT;
      default:                           cls = CL_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// 4-bit register field to one-hot enable vector; all zero when disabled or
// when the field names a register beyond NUM_REGS.
module reg_select_decoder #(
  parameter int unsigned NUM_REGS = 16
) (
  input  logic [3:0]          field,
  input  logic                enable,
  output logic [NUM_REGS-1:0] onehot
);

  // Decode field into a single set bit
  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (enable && (32'(field) == i)) onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch T0-T2 with a ready/timeout handshake in T1,
// then execute T3-T6 decoded from the IR opcode.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned NUM_REGS    = 16
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                run,
  input  logic                mem_ready,
  input  logic [31:0]         ir,
  output logic                PCout,
  output logic                MARin,
  output logic                incPC,
  output logic                PCin,
  output logic                read,
  output logic                MDRin,
  output logic                MDRout,
  output logic                IRin,
  output logic                Yin,
  output logic                Zin,
  output logic                ZLowOut,
  output logic                ZHighOut,
  output logic                HIin,
  output logic                LOin,
  output logic [NUM_REGS-1:0] Rin,
  output logic [NUM_REGS-1:0] Rout,
  output logic [4:0]          opcode,
  output logic                busy,
  output logic                halted,
  output logic                illegal,
  output logic                bus_error
);

  localparam logic [7:0] TIMEOUT_LIM = 8'(MEM_TIMEOUT);

  state_t    state, state_next, end_state;
  logic [7:0] wait_cnt, wait_cnt_next;
  logic       bus_error_next;
  logic [4:0] ir_op;
  logic [3:0] ra, rb, rc, rout_sel;
  logic       rin_en, rout_en;
  op_class_t  cls;
  logic       unused_ir;

  assign ir_op     = ir[IR_OPC_LSB +: 5];
  assign ra        = ir[IR_RA_LSB +: 4];
  assign rb        = ir[IR_RB_LSB +: 4];
  assign rc        = ir[IR_RC_LSB +: 4];
  assign cls       = classify(ir_op);
  assign end_state = run ? ST_T0 : ST_IDLE;
  assign unused_ir = ^ir[IR_RC_LSB-1:0];

  // State, wait counter and sticky bus error register
  always_ff @(posedge clock) begin
    if (clear) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      bus_error <= 1'b0;
    end else begin
      state     <= state_next;
      wait_cnt  <= wait_cnt_next;
      bus_error <= bus_error_next;
    end
  end

  // Next-state and strobe decode from state and IR
  always_comb begin
    state_next     = state;
    wait_cnt_next  = wait_cnt;
    bus_error_next = bus_error;
    PCout = 1'b0; MARin = 1'b0; incPC = 1'b0; PCin = 1'b0; read = 1'b0;
    MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0; Yin = 1'b0; Zin = 1'b0;
    ZLowOut = 1'b0; ZHighOut = 1'b0; HIin = 1'b0; LOin = 1'b0;
    opcode   = '0;
    illegal  = 1'b0;
    rin_en   = 1'b0;
    rout_en  = 1'b0;
    rout_sel = rb;
    busy     = (state != ST_IDLE) && (state != ST_HALT);
    halted   = (state == ST_HALT);
    case (state)
      ST_IDLE: if (run) state_next = ST_T0;
      ST_T0: begin
        PCout = 1'b1; MARin = 1'b1; incPC = 1'b1; Zin = 1'b1;
        wait_cnt_next = '0;
        state_next    = ST_T1;
      end
      ST_T1: begin
        ZLowOut = 1'b1; PCin = 1'b1; read = 1'b1; MDRin = 1'b1;
        // ready in the cycle the count would expire still completes the read
        if (mem_ready) begin
          state_next = ST_T2;
        end else if (wait_cnt + 8'd1 == TIMEOUT_LIM) begin
          bus_error_next = 1'b1;
          state_next     = ST_HALT;
        end else begin
          wait_cnt_next = wait_cnt + 8'd1;
        end
      end
      ST_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        state_next = ST_T3;
      end
      ST_T3: begin
        case (cls)
          CL_ALU3, CL_MULDIV: begin
            rout_en = 1'b1; Yin = 1'b1;
            state_next = ST_T4;
          end
          CL_UNARY: begin
            rout_en = 1'b1; opcode = ir_op; Zin = 1'b1;
            state_next = ST_T4;
          end
          CL_NOP:  state_next = end_state;
          CL_HALT: state_next = ST_HALT;
          default: begin
            illegal    = 1'b1;
            state_next = end_state;
          end
        endcase
      end
      ST_T4: begin
        case (cls)
          CL_ALU3, CL_MULDIV: begin
            rout_en = 1'b1; rout_sel = rc; opcode = ir_op; Zin = 1'b1;
            state_next = ST_T5;
          end
          CL_UNARY: begin
            ZLowOut = 1'b1; rin_en = 1'b1;
            state_next = end_state;
          end
          default: state_next = end_state;
        endcase
      end
      ST_T5: begin
        case (cls)
          CL_ALU3: begin
            ZLowOut = 1'b1; rin_en = 1'b1;
            state_next = end_state;
          end
          CL_MULDIV: begin
            ZLowOut = 1'b1; LOin = 1'b1;
            state_next = ST_T6;
          end
          default: state_next = end_state;
        endcase
      end
      ST_T6: begin
        ZHighOut = 1'b1; HIin = 1'b1;
        state_next = end_state;
      end
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_IDLE;
    endcase
  end

  reg_select_decoder #(.NUM_REGS(NUM_REGS)) u_rin_dec (
    .field  (ra),
    .enable (rin_en),
    .onehot (Rin)
  );

  reg_select_decoder #(.NUM_REGS(NUM_REGS)) u_rout_dec (
    .field  (rout_sel),
    .enable (rout_en),
    .onehot (Rout)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: a per-instruction expected-cycle list is built
// from the instruction's class and fields, then replayed against the DUT.
module tb_control_sequencer;

  localparam int unsigned MEM_TIMEOUT = 15;
  localparam int unsigned NUM_REGS    = 16;

  typedef struct packed {
    logic pcout, marin, incpc, pcin, read, mdrin, mdrout, irin, yin, zin;
    logic zlo, zhi, hiin, loin;
    logic [15:0] rin, rout;
    logic [4:0]  opc;
    logic busy, halted, illegal, berr;
  } obs_t;

  typedef struct {
    string       tag;
    obs_t        e;
    logic        rdy;
    logic        run;
    logic [31:0] ir;
  } rec_t;

  logic clock = 1'b0;
  logic clear, run, mem_ready;
  logic [31:0] ir;
  logic PCout, MARin, incPC, PCin, read, MDRin, MDRout, IRin, Yin, Zin;
  logic ZLowOut, ZHighOut, HIin, LOin;
  logic [NUM_REGS-1:0] Rin, Rout;
  logic [4:0] opcode;
  logic busy, halted, illegal, bus_error;
  obs_t obs;

  rec_t        q[$];
  logic        cur_run;
  logic [31:0] cur_ir;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  control_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT), .NUM_REGS(NUM_REGS)) dut (
    .clock(clock), .clear(clear), .run(run), .mem_ready(mem_ready), .ir(ir),
    .PCout(PCout), .MARin(MARin), .incPC(incPC), .PCin(PCin), .read(read),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .ZLowOut(ZLowOut), .ZHighOut(ZHighOut), .HIin(HIin), .LOin(LOin),
    .Rin(Rin), .Rout(Rout), .opcode(opcode), .busy(busy), .halted(halted),
    .illegal(illegal), .bus_error(bus_error)
  );

  always #5 clock = ~clock;

  assign obs = {PCout, MARin, incPC, PCin, read, MDRin, MDRout, IRin, Yin, Zin,
                ZLowOut, ZHighOut, HIin, LOin, Rin, Rout, opcode,
                busy, halted, illegal, bus_error};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input obs_t e, input logic rdy);
    rec_t r;
    r.tag = tag; r.e = e; r.rdy = rdy; r.run = cur_run; r.ir = cur_ir;
    q.push_back(r);
  endtask

  function automatic obs_t active();
    obs_t o = '0;
    o.busy = 1'b1;
    return o;
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Parked in IDLE: two cycles with run low (no fetch may start), then run high
  task automatic model_idle(input string nm);
    cur_run = 1'b0;
    push({nm, ".idle0"}, '0, rnd_bit());
    push({nm, ".idle0"}, '0, rnd_bit());
    cur_run = 1'b1;
    push({nm, ".idle1"}, '0, rnd_bit());
  endtask

  task automatic model_halted(input string nm, input int unsigned n, input logic berr);
    obs_t e;
    e = '0; e.halted = 1'b1; e.berr = berr;
    for (int unsigned i = 0; i < n; i++) push({nm, ".halt"}, e, rnd_bit());
  endtask

  task automatic model_fetch(input string nm, input int unsigned waits);
    obs_t e;
    e = active(); e.pcout = 1'b1; e.marin = 1'b1; e.incpc = 1'b1; e.zin = 1'b1;
    push({nm, ".T0"}, e, rnd_bit());
    for (int unsigned i = 0; i <= waits; i++) begin
      e = active(); e.zlo = 1'b1; e.pcin = 1'b1; e.read = 1'b1; e.mdrin = 1'b1;
      push({nm, ".T1"}, e, (i == waits));
    end
    e = active(); e.mdrout = 1'b1; e.irin = 1'b1;
    push({nm, ".T2"}, e, rnd_bit());
  endtask

  // Expected cycles of one full instruction derived from its opcode class
  task automatic model_instr(input logic [31:0] w, input int unsigned waits,
                             input logic run_after, input string nm);
    int unsigned op, ra, rb, rc;
    obs_t e;
    op = (w >> 27) & 32'h1f;
    ra = (w >> 23) & 32'hf;
    rb = (w >> 19) & 32'hf;
    rc = (w >> 15) & 32'hf;
    cur_ir  = w;
    cur_run = run_after;
    model_fetch(nm, waits);
    if ((op >= 3 && op <= 11) || op == 14 || op == 15) begin
      e = active(); e.rout = 16'd1 << rb; e.yin = 1'b1;
      push({nm, ".T3"}, e, rnd_bit());
      e = active(); e.rout = 16'd1 << rc; e.opc = 5'(op); e.zin = 1'b1;
      push({nm, ".T4"}, e, rnd_bit());
      if (op <= 11) begin
        e = active(); e.zlo = 1'b1; e.rin = 16'd1 << ra;
        push({nm, ".T5"}, e, rnd_bit());
      end else begin
        e = active(); e.zlo = 1'b1; e.loin = 1'b1;
        push({nm, ".T5"}, e, rnd_bit());
        e = active(); e.zhi = 1'b1; e.hiin = 1'b1;
        push({nm, ".T6"}, e, rnd_bit());
      end
    end else if (op == 16 || op == 17) begin
      e = active(); e.rout = 16'd1 << rb; e.opc = 5'(op); e.zin = 1'b1;
      push({nm, ".T3"}, e, rnd_bit());
      e = active(); e.zlo = 1'b1; e.rin = 16'd1 << ra;
      push({nm, ".T4"}, e, rnd_bit());
    end else if (op == 26) begin
      push({nm, ".T3"}, active(), rnd_bit());
    end else if (op == 27) begin
      push({nm, ".T3"}, active(), rnd_bit());
      model_halted(nm, 20, 1'b0);
      return;
    end else begin
      e = active(); e.illegal = 1'b1;
      push({nm, ".T3"}, e, rnd_bit());
    end
    if (!run_after) model_idle(nm);
  endtask

  task automatic run_queue(input logic clear_on_last);
    rec_t r;
    while (q.size() != 0) begin
      r = q.pop_front();
      ir = r.ir; mem_ready = r.rdy; run = r.run;
      @(negedge clock);
      check_eq(r.tag, 64'(obs), 64'(r.e));
      if (q.size() == 0 && clear_on_last) clear = 1'b1;
      @(posedge clock);
      #1;
      clear = 1'b0;
    end
  endtask

  initial begin
    logic [4:0] op;
    clear = 1'b1; run = 1'b0; mem_ready = 1'b0; ir = '0;
    cur_ir = '0; cur_run = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    clear = 1'b0;

    // reset state, then directed instructions from the plan
    model_idle("rst");
    model_instr(32'h78130000, 0, 1'b1, "DIV");
    model_instr(32'h1A1B8000, 3, 1'b1, "ADD");
    model_instr({5'b10000, 4'd5, 4'd9, 4'd1, 15'd0}, MEM_TIMEOUT - 1, 1'b0, "NEGedge");
    model_instr({5'b11111, 27'h1234567}, 1, 1'b1, "ILL");
    model_instr({5'b11010, 27'h0}, 0, 1'b0, "NOP");
    model_instr({5'b01110, 4'd3, 4'd3, 4'd3, 15'd0}, 2, 1'b1, "MULsame");
    run_queue(1'b0);

    // randomized instruction stream
    for (int n = 0; n < 40; n++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'd27) op = 5'd26;
      model_instr({op, 27'($urandom)}, $urandom_range(0, 4),
                  ($urandom_range(0, 3) != 0), "RND");
    end
    run_queue(1'b0);

    // clear during T4 of a DIV
    model_instr(32'h78130000, 1, 1'b1, "DIVclr");
    void'(q.pop_back());
    void'(q.pop_back());
    run_queue(1'b1);
    model_idle("postclr");
    run_queue(1'b0);

    // HALT instruction, held, then released by clear
    model_instr({5'b11011, 27'h0}, 0, 1'b1, "HALT");
    run_queue(1'b1);
    model_idle("posthalt");
    run_queue(1'b0);

    // memory never ready: timeout into HALT with bus_error
    cur_run = 1'b1;
    cur_ir  = 32'h1A1B8000;
    model_fetch("TMO", MEM_TIMEOUT + 5);
    while (q.size() > 1 + MEM_TIMEOUT) void'(q.pop_back());
    for (int i = 1; i < q.size(); i++) q[i].rdy = 1'b0;
    model_halted("TMO", 5, 1'b1);
    run_queue(1'b1);
    model_idle("posttmo");
    run_queue(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
